custom_ip_reg_sched: RTL and testbench

Request scheduler in front of the `custom_axi_ip` register-to-hardware port. It lets NUM_REQ requesters share the 96-bit `reg2ip` write path and the 99-bit `ip2reg` read snapshot. Requests are granted round-robin and serialised into one transaction at a time. Each transaction ends with a one-cycle response that carries the read data or an error flag.

---
 rtl/custom_ip_pkg.sv | 41 ++++
 rtl/custom_ip_rr_arb.sv | 43 ++++
 rtl/custom_ip_reg_sched.sv | 142 ++++++++++++++
 tb/tb_custom_ip_reg_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_ip_pkg.sv
// Shared types and slice positions for the custom_axi_ip register scheduler.
package custom_ip_pkg;

  localparam int REG_IDX_W = 2;
  localparam logic [REG_IDX_W-1:0] ILLEGAL_IDX = 2'd3;

  localparam int WR_LSB_0 = 64;
  localparam int WR_LSB_1 = 32;
  localparam int WR_LSB_2 = 0;
  localparam int RD_LSB_0 = 67;
  localparam int RD_LSB_1 = 34;
  localparam int RD_LSB_2 = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STROBE,
    ST_WR_WAIT,
    ST_RD_SETTLE0,
    ST_RD_SETTLE1,
    ST_RESP
  } state_t;

  function automatic logic [95:0] wr_place(input logic [REG_IDX_W-1:0] idx, input logic [31:0] word);
    case (idx)
      2'd0:    wr_place = 96'(word) << WR_LSB_0;
      2'd1:    wr_place = 96'(word) << WR_LSB_1;
      2'd2:    wr_place = 96'(word) << WR_LSB_2;
      default: wr_place = '0;
    endcase
  endfunction

  function automatic logic [31:0] rd_pick(input logic [98:0] snap, input logic [REG_IDX_W-1:0] idx);
    case (idx)
      2'd0:    rd_pick = snap[RD_LSB_0 +: 32];
      2'd1:    rd_pick = snap[RD_LSB_1 +: 32];
      2'd2:    rd_pick = snap[RD_LSB_2 +: 32];
      default: rd_pick = '0;
    endcase
  endfunction

endpackage

// File: rtl/custom_ip_rr_arb.sv
// Round-robin arbiter: combinational grant from the request vector, pointer
// moves past the owner on each advance pulse.
module custom_ip_rr_arb #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [PTR_W-1:0]   owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [PTR_W-1:0] ptr_q;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    end
  end

endmodule

// File: rtl/custom_ip_reg_sched.sv
// Serialises NUM_REQ requesters onto the custom_axi_ip reg2ip/ip2reg port.
//   state         | meaning
//   ST_IDLE       | arbitrate, latch winner's request
//   ST_WR_STROBE  | one-cycle write enable to the IP
//   ST_WR_WAIT    | wait for ack[0] or timeout
//   ST_RD_SETTLE0 | first settle cycle of the read snapshot
//   ST_RD_SETTLE1 | second settle cycle, capture read slice
//   ST_RESP       | one-cycle response to the owner
module custom_ip_reg_sched
  import custom_ip_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [NUM_REQ*2-1:0]   req_idx_i,
  input  logic [NUM_REQ*32-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [95:0]            reg2ip_data_o,
  output logic [2:0]             reg2ip_en_o,
  input  logic [2:0]             reg2ip_en_ack_i,
  input  logic [98:0]            ip2reg_data_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t state_q, state_d;

  logic [NUM_REQ-1:0]   arb_req, grant;
  logic [PTR_W-1:0]     grant_idx, owner_q;
  logic                 grant_any;
  logic                 sel_write;
  logic [REG_IDX_W-1:0] sel_idx, idx_q;
  logic [31:0]          sel_wdata, rdata_q;
  logic [95:0]          data_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;
  logic                 ack, timeout;
  logic                 unused_ack;

  assign ack        = reg2ip_en_ack_i[0];
  assign unused_ack = ^reg2ip_en_ack_i[2:1];
  assign timeout    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign arb_req    = (state_q == ST_IDLE && !rst_i) ? req_valid_i : '0;

  custom_ip_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (arb_req),
    .advance   (state_q == ST_RESP),
    .owner     (owner_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready_o = grant;

  always_comb begin
    sel_write = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_write = req_write_i[i];
        sel_idx   = req_idx_i[i*REG_IDX_W +: REG_IDX_W];
        sel_wdata = req_wdata_i[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          if (sel_idx == ILLEGAL_IDX) state_d = ST_RESP;
          else if (sel_write)         state_d = ST_WR_STROBE;
          else                        state_d = ST_RD_SETTLE0;
        end
      end
      ST_WR_STROBE:  state_d = ST_WR_WAIT;
      ST_WR_WAIT:    if (ack || timeout) state_d = ST_RESP;
      ST_RD_SETTLE0: state_d = ST_RD_SETTLE1;
      ST_RD_SETTLE1: state_d = ST_RESP;
      ST_RESP:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            owner_q <= grant_idx;
            idx_q   <= sel_idx;
            err_q   <= (sel_idx == ILLEGAL_IDX);
            rdata_q <= '0;
            cnt_q   <= '0;
            if (sel_write && sel_idx != ILLEGAL_IDX) data_q <= wr_place(sel_idx, sel_wdata);
          end
        end
        ST_WR_WAIT: begin
          // ack on the final wait cycle still wins over the timeout
          if (!ack) begin
            if (timeout) err_q <= 1'b1;
            if (cnt_q != CNT_W'(ACK_TIMEOUT)) cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RD_SETTLE1: rdata_q <= rd_pick(ip2reg_data_i, idx_q);
        default: ;
      endcase
    end
  end

  assign reg2ip_en_o   = (state_q == ST_WR_STROBE) ? (3'b001 << idx_q) : 3'b000;
  assign reg2ip_data_o = data_q;
  assign rsp_valid_o   = (state_q == ST_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign rsp_err_o     = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o   = (state_q == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_custom_ip_reg_sched.sv
// Randomised bench for custom_ip_reg_sched against a transaction-level model.
module tb_custom_ip_reg_sched;

  localparam int NR = 2;
  localparam int TO = 15;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
  logic [NR*2-1:0]  req_idx_i;
  logic [NR*32-1:0] req_wdata_i;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_err_o;
  logic [95:0]      reg2ip_data_o;
  logic [2:0]       reg2ip_en_o, reg2ip_en_ack_i;
  logic [98:0]      ip2reg_data_i;

  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;

  custom_ip_reg_sched #(.NUM_REQ(NR), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_idx_i(req_idx_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
    .reg2ip_en_ack_i(reg2ip_en_ack_i), .ip2reg_data_i(ip2reg_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [95:0] model_wr(input logic [1:0] ix, input logic [31:0] d);
    case (ix)
      2'd0:    model_wr = {d, 64'h0};
      2'd1:    model_wr = {32'h0, d, 32'h0};
      2'd2:    model_wr = {64'h0, d};
      default: model_wr = 96'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [98:0] s, input logic [1:0] ix);
    case (ix)
      2'd0:    model_rd = s[98:67];
      2'd1:    model_rd = s[65:34];
      2'd2:    model_rd = s[32:1];
      default: model_rd = 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_step();
    req_valid_i = '0;
    step();
  endtask

  task automatic set_fields(input int r, input logic w, input logic [1:0] ix, input logic [31:0] d);
    req_write_i[r]         = w;
    req_idx_i[r*2 +: 2]    = ix;
    req_wdata_i[r*32 +: 32] = d;
  endtask

  task automatic rand_fields();
    logic [1:0] ix;
    for (int r = 0; r < NR; r++) begin
      ix = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ix = 2'd3;
      set_fields(r, 1'($urandom_range(0, 1)), ix, $urandom);
    end
  endtask

  // One transaction from the grant cycle through the response cycle.
  // ack_d: WR_WAIT cycles before ack (0 = first cycle), -1 = ack never comes.
  task automatic run_txn(input logic [NR-1:0] vmask, input bit hold, input int ack_d, input bit ack_noise);
    int w, lat, j;
    logic wr, legal_wr, exp_err;
    logic [1:0] ix;
    logic [31:0] wd, exp_rd;
    logic [95:0] exp_data;
    logic [2:0] exp_en;
    logic [NR-1:0] exp_rdy, exp_vld;
    w = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      j = (exp_ptr + i) % NR;
      if (vmask[j]) w = j;
    end
    wr = req_write_i[w];
    ix = req_idx_i[w*2 +: 2];
    wd = req_wdata_i[w*32 +: 32];
    legal_wr = wr && (ix != 2'd3);
    exp_data = model_wr(ix, wd);
    exp_rd = 32'h0;
    if (ix == 2'd3) begin
      lat = 1; exp_err = 1'b1;
    end else if (wr) begin
      if (ack_d < 0) begin lat = 2 + TO; exp_err = 1'b1; end
      else begin lat = 3 + ack_d; exp_err = 1'b0; end
    end else begin
      lat = 3; exp_err = 1'b0; exp_rd = model_rd(ip2reg_data_i, ix);
    end
    req_valid_i = vmask;
    reg2ip_en_ack_i = 3'b000;
    #1;
    exp_rdy = '0;
    exp_rdy[w] = 1'b1;
    total++;
    if (req_ready_o !== exp_rdy) begin
      bad++; $display("FAIL grant_ready got=%b want=%b", req_ready_o, exp_rdy);
    end
    for (int k = 1; k <= lat; k++) begin
      step();
      if (!hold) req_valid_i = '0;
      reg2ip_en_ack_i = 3'b000;
      if (legal_wr && k == 1 && ack_noise) reg2ip_en_ack_i = 3'b001;
      if (legal_wr && ack_d >= 0 && k == 2 + ack_d) reg2ip_en_ack_i = 3'b001;
      total++;
      if (req_ready_o !== '0) begin
        bad++; $display("FAIL busy_ready k=%0d got=%b want=0", k, req_ready_o);
      end
      exp_en = (legal_wr && k == 1) ? (3'b001 << ix) : 3'b000;
      total++;
      if (reg2ip_en_o !== exp_en) begin
        bad++; $display("FAIL en k=%0d got=%b want=%b", k, reg2ip_en_o, exp_en);
      end
      if (legal_wr && k < lat) begin
        total++;
        if (reg2ip_data_o !== exp_data) begin
          bad++; $display("FAIL wr_data k=%0d got=%h want=%h", k, reg2ip_data_o, exp_data);
        end
      end
      exp_vld = '0;
      if (k == lat) exp_vld[w] = 1'b1;
      total++;
      if (rsp_valid_o !== exp_vld) begin
        bad++; $display("FAIL rsp_valid k=%0d got=%b want=%b", k, rsp_valid_o, exp_vld);
      end
      if (k == lat) begin
        total++;
        if (rsp_err_o !== exp_err) begin
          bad++; $display("FAIL rsp_err got=%b want=%b", rsp_err_o, exp_err);
        end
        total++;
        if (rsp_rdata_o !== exp_rd) begin
          bad++; $display("FAIL rsp_rdata got=%h want=%h", rsp_rdata_o, exp_rd);
        end
      end
    end
    reg2ip_en_ack_i = 3'b000;
    exp_ptr = (w + 1) % NR;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = '0; req_write_i = '0; req_idx_i = '0; req_wdata_i = '0;
    reg2ip_en_ack_i = '0; ip2reg_data_i = '0;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o} !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {req_ready_o, rsp_valid_o, rsp_err_o});
    end
    total++;
    if (rsp_rdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata_o);
    end
    total++;
    if (reg2ip_data_o !== 96'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", reg2ip_data_o);
    end
    total++;
    if (reg2ip_en_o !== 3'b000) begin
      bad++; $display("FAIL reset_en got=%b want=000", reg2ip_en_o);
    end
    exp_ptr = 0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      rand_fields();
      run_txn(2'b11, 1'b1, $urandom_range(0, 2), 1'b0);
      step();
    end
    req_valid_i = '0;
    step();
  endtask

  task automatic test_write();
    set_fields(0, 1'b1, 2'd1, 32'hDEADBEEF);
    set_fields(1, 1'b0, 2'd0, $urandom);
    run_txn(2'b01, 1'b0, 0, 1'b0);
    idle_step();
    set_fields(1, 1'b1, 2'd0, $urandom);
    run_txn(2'b10, 1'b0, 2, 1'b1);
    idle_step();
    set_fields(0, 1'b1, 2'd2, $urandom);
    run_txn(2'b01, 1'b0, 3, 1'b1);
    idle_step();
  endtask

  task automatic test_read();
    logic [1:0] ixs [3];
    ixs[0] = 2'd2; ixs[1] = 2'd0; ixs[2] = 2'd1;
    ip2reg_data_i = {32'h2468, 1'b0, 32'h369C, 1'b0, 32'h48D0, 1'b0};
    for (int n = 0; n < 3; n++) begin
      set_fields(0, 1'b0, ixs[n], $urandom);
      run_txn(2'b01, 1'b0, 0, 1'b0);
      idle_step();
    end
  endtask

  task automatic test_timeout();
    set_fields(1, 1'b1, 2'd2, $urandom);
    run_txn(2'b10, 1'b0, -1, 1'b1);
    idle_step();
  endtask

  task automatic test_illegal();
    set_fields(0, 1'b1, 2'd3, $urandom);
    run_txn(2'b01, 1'b0, 0, 1'b0);
    idle_step();
    set_fields(1, 1'b0, 2'd3, $urandom);
    run_txn(2'b10, 1'b0, 0, 1'b0);
    idle_step();
  endtask

  task automatic test_reset_mid();
    set_fields(0, 1'b0, 2'd0, $urandom);
    if (exp_ptr != 1) begin
      run_txn(2'b01, 1'b0, 0, 1'b0);
      idle_step();
    end
    set_fields(1, 1'b1, 2'd0, $urandom);
    req_valid_i = 2'b10;
    #1;
    total++;
    if (req_ready_o !== 2'b10) begin
      bad++; $display("FAIL mid_grant got=%b want=10", req_ready_o);
    end
    step();
    req_valid_i = '0;
    step();
    step();
    rst_i = 1'b1;
    step();
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, reg2ip_en_o} !== '0) begin
      bad++; $display("FAIL mid_rst_ctrl got=%b want=0", {req_ready_o, rsp_valid_o, rsp_err_o, reg2ip_en_o});
    end
    total++;
    if ({reg2ip_data_o, rsp_rdata_o} !== '0) begin
      bad++; $display("FAIL mid_rst_data got=%h want=0", {reg2ip_data_o, rsp_rdata_o});
    end
    rst_i = 1'b0;
    exp_ptr = 0;
    for (int n = 0; n < TO + 4; n++) begin
      step();
      total++;
      if (rsp_valid_o !== '0 || reg2ip_en_o !== 3'b000) begin
        bad++; $display("FAIL mid_rst_quiet n=%0d rsp=%b en=%b want=0", n, rsp_valid_o, reg2ip_en_o);
      end
    end
    set_fields(0, 1'b0, 2'd1, $urandom);
    set_fields(1, 1'b0, 2'd2, $urandom);
    run_txn(2'b11, 1'b0, 0, 1'b0);
    idle_step();
  endtask

  task automatic test_random();
    logic [NR-1:0] vm;
    bit hold;
    int ad;
    for (int n = 0; n < 40; n++) begin
      rand_fields();
      ip2reg_data_i = {$urandom, $urandom, $urandom, 3'($urandom_range(0, 7))};
      vm = NR'($urandom_range(1, 3));
      hold = ($urandom_range(0, 1) == 1);
      ad = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(vm, hold, ad, ($urandom_range(0, 1) == 1));
      if (hold) step();
      else begin
        idle_step();
        repeat ($urandom_range(0, 2)) step();
      end
    end
    idle_step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write();
    test_read();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
